// File: rtl/bound_flasher_monitor_if.sv
// Observation bus between the 16-bit LED flasher (master side) and its passive monitor (slave side).
// The monitor only ever reads led_i/clr; everything else is decoded status it drives back.
interface bound_flasher_monitor_if #(
  parameter int CNT_W = 8
);
  logic [15:0]      led_i;
  logic             clr;
  logic [4:0]       level_o;
  logic [1:0]       dir_o;
  logic             busy_o;
  logic             peak_valid;
  logic [4:0]       peak_level;
  logic             trough_valid;
  logic [4:0]       trough_level;
  logic             seq_done;
  logic [CNT_W-1:0] seq_count;
  logic             err_shape;
  logic             err_step;
  logic             err_bound;

  modport master (
    output led_i, clr,
    input  level_o, dir_o, busy_o, peak_valid, peak_level, trough_valid,
           trough_level, seq_done, seq_count, err_shape, err_step, err_bound
  );

  modport slave (
    input  led_i, clr,
    output level_o, dir_o, busy_o, peak_valid, peak_level, trough_valid,
           trough_level, seq_done, seq_count, err_shape, err_step, err_bound
  );
endinterface

// File: rtl/bound_flasher_monitor.sv
// Passive decoder for the LED flasher bus: tracks level and direction, reports turnarounds,
// completed sequences and sticky protocol errors. Every output is registered.
module bound_flasher_monitor #(
  parameter int IDLE_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bound_flasher_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RISE = 2'b01,
    FALL = 2'b10
  } state_e;

  state_e           state_q;
  logic [4:0]       level_q;
  logic [4:0]       prev_q;
  logic [3:0]       zero_run_q;
  logic [1:0]       dir_q;
  logic             busy_q;
  logic             peak_valid_q;
  logic [4:0]       peak_level_q;
  logic             trough_valid_q;
  logic [4:0]       trough_level_q;
  logic             seq_done_q;
  logic [CNT_W-1:0] seq_count_q;
  logic             err_shape_q;
  logic             err_step_q;
  logic             err_bound_q;

  logic             legal_d;
  logic [4:0]       level_d;
  logic signed [5:0] delta_d;
  logic [3:0]       zero_inc_d;
  logic             big_step_d;
  logic             peak_bad_d;
  logic             trough_bad_d;

  // Decode of the current sample; a legal code is a run of ones starting at bit 0.
  always_comb begin
    legal_d = ((bus.led_i & (bus.led_i + 16'd1)) == 16'd0);
    level_d = '0;
    for (int i = 0; i < 16; i++) begin
      level_d = level_d + {4'd0, bus.led_i[i]};
    end
    delta_d      = $signed({1'b0, level_d}) - $signed({1'b0, prev_q});
    big_step_d   = (delta_d > 6'sd1) || (delta_d < -6'sd1);
    zero_inc_d   = (zero_run_q == 4'd15) ? zero_run_q : zero_run_q + 4'd1;
    peak_bad_d   = !(prev_q inside {5'd16, 5'd11, 5'd7});
    trough_bad_d = !(prev_q inside {5'd5, 5'd0});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      level_q        <= '0;
      prev_q         <= '0;
      zero_run_q     <= '0;
      dir_q          <= 2'b00;
      busy_q         <= 1'b0;
      peak_valid_q   <= 1'b0;
      peak_level_q   <= '0;
      trough_valid_q <= 1'b0;
      trough_level_q <= '0;
      seq_done_q     <= 1'b0;
      seq_count_q    <= '0;
      err_shape_q    <= 1'b0;
      err_step_q     <= 1'b0;
      err_bound_q    <= 1'b0;
    end else begin
      peak_valid_q   <= 1'b0;
      trough_valid_q <= 1'b0;
      seq_done_q     <= 1'b0;
      // Later assignments below override the clear, so a same-cycle event wins.
      if (bus.clr) begin
        seq_count_q <= '0;
        err_shape_q <= 1'b0;
        err_step_q  <= 1'b0;
        err_bound_q <= 1'b0;
      end
      if (!legal_d) begin
        err_shape_q <= 1'b1;
      end else begin
        level_q <= level_d;
        prev_q  <= level_d;
        if (big_step_d) begin
          err_step_q <= 1'b1;
          busy_q     <= 1'b1;
          if (level_d == 5'd0) begin
            state_q    <= FALL;
            dir_q      <= 2'b10;
            zero_run_q <= 4'd1;
          end else begin
            state_q    <= RISE;
            dir_q      <= 2'b01;
            zero_run_q <= 4'd0;
          end
        end else begin
          unique case (state_q)
            IDLE: begin
              if (level_d == 5'd1 && delta_d == 6'sd1) begin
                state_q    <= RISE;
                dir_q      <= 2'b01;
                busy_q     <= 1'b1;
                zero_run_q <= 4'd0;
              end
            end
            RISE: begin
              if (delta_d == -6'sd1) begin
                state_q      <= FALL;
                dir_q        <= 2'b10;
                peak_valid_q <= 1'b1;
                peak_level_q <= prev_q;
                zero_run_q   <= (level_d == 5'd0) ? 4'd1 : 4'd0;
                if (peak_bad_d) err_bound_q <= 1'b1;
              end
            end
            FALL: begin
              if (delta_d == 6'sd1) begin
                state_q        <= RISE;
                dir_q          <= 2'b01;
                trough_valid_q <= 1'b1;
                trough_level_q <= prev_q;
                zero_run_q     <= 4'd0;
                if (trough_bad_d) err_bound_q <= 1'b1;
              end else if (level_d != 5'd0) begin
                zero_run_q <= 4'd0;
              end else begin
                zero_run_q <= zero_inc_d;
                if (int'(zero_inc_d) >= IDLE_CYCLES) begin
                  state_q    <= IDLE;
                  dir_q      <= 2'b00;
                  busy_q     <= 1'b0;
                  seq_done_q <= 1'b1;
                  seq_count_q <= bus.clr ? CNT_W'(1) :
                                 ((&seq_count_q) ? seq_count_q : seq_count_q + CNT_W'(1));
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.level_o      = level_q;
  assign bus.dir_o        = dir_q;
  assign bus.busy_o       = busy_q;
  assign bus.peak_valid   = peak_valid_q;
  assign bus.peak_level   = peak_level_q;
  assign bus.trough_valid = trough_valid_q;
  assign bus.trough_level = trough_level_q;
  assign bus.seq_done     = seq_done_q;
  assign bus.seq_count    = seq_count_q;
  assign bus.err_shape    = err_shape_q;
  assign bus.err_step     = err_step_q;
  assign bus.err_bound    = err_bound_q;

endmodule

// File: doc/bound_flasher_monitor.md
Name: bound_flasher_monitor

Overview:
- Passive receiver for the 16-bit LED flasher bus.
- Samples the LED vector every clock and decodes it into a level (0..16) and a direction.
- Reports peak/trough turnarounds and completed flash sequences.
- Flags protocol violations: non-thermometer codes, multi-step jumps, illegal bound levels. Used on-chip as a status/diagnostic source and reused as the bench scoreboard front end.

Parameters:
- IDLE_CYCLES, 3, consecutive zero-level samples in FALL needed to declare the sequence finished (range 2..15).
- CNT_W, 8, width of the saturating completed-sequence counter.

Ports:
- clk  in  1  clock; all sampling on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of seq_count and sticky error flags.
- led_i  in  16  LED bus under observation.
- level_o  out  5  decoded level (number of lit LEDs).
- dir_o  out  2  00 idle, 01 rising, 10 falling.
- busy_o  out  1  high while a sequence is in progress (state != IDLE).
- peak_valid  out  1  one-cycle pulse on an up-to-down turnaround.
- peak_level  out  5  level of the turnaround; valid with peak_valid, held otherwise.
- trough_valid  out  1  one-cycle pulse on a down-to-up turnaround.
- trough_level  out  5  level of the turnaround; valid with trough_valid, held otherwise.
- seq_done  out  1  one-cycle pulse when a sequence completes.
- seq_count  out  CNT_W  completed sequences; saturates at all-ones.
- err_shape  out  1  sticky: led_i was not a thermometer code.
- err_step  out  1  sticky: level changed by more than 1 in one cycle.
- err_bound  out  1  sticky: peak not in {16,11,7}, or trough not in {5,0}.

Behaviour:
- Reset (async) clears all outputs to 0. Internal state: prev_level=0, zero_run=0, FSM=IDLE.
- Every output is a register. Each output reflects the led_i sample taken at the same rising edge, with 1-cycle latency.
- Legal code: led_i & (led_i+1) == 0, i.e. contiguous ones from bit 0. level = popcount(led_i).
- Illegal code:
  - err_shape set.
  - Sample is otherwise ignored: level_o, prev_level, FSM and zero_run unchanged; no pulses.
- delta = level - prev_level, computed in 6-bit signed arithmetic. prev_level updates on every legal sample.
- |delta| > 1:
  - err_step set; no pulses.
  - FSM resyncs: level 0 -> FALL with zero_run=1; otherwise RISE.
  - This is the expected outcome when the flasher is reset mid-sequence.
- delta == 0 in RISE or FALL: no state change. A stall is legal; the flasher holds the bus for one cycle on a flick restart.
- FSM states IDLE, RISE, FALL:
  - IDLE:
    - level 1 with delta +1 -> RISE; busy_o=1; dir_o=01.
    - level 0 stays IDLE.
  - RISE:
    - delta +1 stays.
    - delta -1 -> FALL. peak_valid=1, peak_level=prev_level. err_bound set if prev_level not in {16,11,7}.
  - FALL:
    - delta -1 stays. zero_run resets to 0 on any nonzero level.
    - delta +1 -> RISE. trough_valid=1, trough_level=prev_level. err_bound set if prev_level not in {5,0}. zero_run cleared.
    - level 0: zero_run increments, saturating at 15.
    - zero_run reaching IDLE_CYCLES -> IDLE. seq_done=1; seq_count increments unless saturated; dir_o=00; busy_o=0.
- Flick restart (rise from 0 or 5 after at most 1 held cycle) is a trough, not an error and not a seq_done.
- clr:
  - Clears seq_count, err_shape, err_step and err_bound; FSM unaffected.
  - If an error or seq_done occurs in the same cycle, the set/increment wins. The result is flag=1 and seq_count=1.
- Pulses never overlap: at most one of peak_valid, trough_valid, seq_done per cycle.

Test Plan:
- Full nominal sequence 0->16->5->11->0->7->0, then 0 held:
  - peaks 16, 11, 7; troughs 5, 0.
  - seq_done exactly IDLE_CYCLES=3 cycles after the first final zero; seq_count=1.
  - no error flags.
- Flick restart while falling at level 5 (one held cycle of 0x001F, then 0x003F): trough_valid with trough_level=5; no err; busy_o stays 1.
- Inject 0x0005 mid-rise: err_shape=1; level_o holds; the next legal sample continues with no err_step.
- Jump 0x00FF -> 0x0000 (flasher reset): err_step=1; FSM->FALL; seq_done after 2 further zero samples.
- Early turnaround at level 9 during rise: peak_valid with peak_level=9 and err_bound=1. Then assert clr in the same cycle as a second bad peak: err_bound remains 1.
- 260 nominal sequences: seq_count saturates at 255. Assert rst_n low mid-sequence: all outputs 0 asynchronously.
